alu_ctrl: RTL and testbench
===========================

# alu_ctrl

Two-port request scheduler for the shared 4-bit ALU datapath. It arbitrates round-robin between two requesters and latches the granted operation (NOT, AND, OR, ADD). It executes the operation in a dedicated cycle through the combinational ALU core, then holds the result on a valid/ready response port until it is consumed. It sits between the instruction-issue logic and the ALU, so the ALU is a single shared resource and is never driven by two sources at once.

## Interface
- W, 4: operand/result width in bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  2  per-requester request strobe; bit i belongs to requester i.
- req_ready  output  2  per-requester accept; at most one bit high.
- req_op  input  4  packed 2-bit opcodes; [1:0] is requester 0, [3:2] is requester 1.
- req_a  input  2*W  packed operand A; [W-1:0] is requester 0.
- req_b  input  2*W  packed operand B; same packing as req_a.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  1  index of the requester that owns rsp_data.
- rsp_data  output  W  result.
- rsp_zero, rsp_carry  output  1 each  status flags; present only with ALU_CTRL_FLAGS_EN.

## Operation
- Opcodes:
  - 00 = NOT A (~A; B ignored).
  - 01 = A AND B.
  - 10 = A OR B.
  - 11 = A + B, modulo 2^W; the carry out goes to rsp_carry.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, select the grant g and drive req_ready[g]=1 combinationally in the same cycle.
  - On that edge, latch op, A, B and g, and go to EXEC.
  - If no req_valid is high, stay in IDLE with req_ready=00.
- Arbitration:
  - Only one requester valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - last_grant updates to g on every acceptance.
- EXEC:
  - The ALU core computes on the latched operands.
  - Register rsp_data, rsp_id and the flags.
  - Go to RESP unconditionally.
- RESP:
  - rsp_valid=1.
  - On rsp_valid && rsp_ready, go to IDLE; rsp_valid drops the next cycle.
  - rsp_data, rsp_id and the flags hold stable while waiting.
- req_ready is 00 in EXEC and RESP. Requesters must hold req_* stable until they are accepted.
- A requester that deasserts req_valid before acceptance is simply not granted; no error.
- The core is combinational and has no internal state.

## Timing
- Reset values:
  - FSM = IDLE.
  - last_grant = 1, so requester 0 wins the first tie.
  - rsp_valid=0, rsp_id=0, rsp_data=0, flags=0.
  - req_ready is 00 unless a request is valid while in IDLE.
- Latency: acceptance at edge N, rsp_valid high after edge N+1 and observable in cycle N+2.
- Peak throughput: one operation per 3 cycles when rsp_ready is tied high.
- Reset asserted mid-operation (EXEC or RESP) aborts the transaction: no response is produced and all state returns to its reset values immediately.
- No accept happens in the cycle the response is consumed. A new accept is possible from the next cycle, in IDLE.

## Configuration
- ALU_CTRL_FLAGS_EN defined:
  - rsp_zero = (result == 0).
  - rsp_carry = carry out of ADD; 0 for the other opcodes.
  - Both flags are registered alongside rsp_data.
- ALU_CTRL_FLAGS_EN undefined: the rsp_zero and rsp_carry ports and their registers do not exist; everything else is identical.

## Structure
- Shared package alu_pkg holds:
  - W default.
  - alu_op_e enum: OP_NOT, OP_AND, OP_OR, OP_ADD.
  - alu_ctrl_state_e enum: IDLE, EXEC, RESP.
- One sub-module, alu_core (combinational): ports op, a, b → y, carry. It subsumes the standalone inverter function as OP_NOT.

## Test plan
- Reset: hold rst_n=0 with random inputs → rsp_valid=0, rsp_data=0, rsp_id=0, FSM in IDLE.
- Single NOT: requester 0 sends op=00, A=4'b1010 → req_ready=01 for one cycle, rsp_valid two cycles later with rsp_data=4'b0101, rsp_id=0.
- Tie fairness: both valid continuously, rsp_ready=1 → grants alternate in the order 0,1,0,1, with rsp_id matching each grant.
- Backpressure: rsp_ready=0 for 3 cycles in RESP → rsp_data stays constant, req_ready=00 throughout; the response completes on the first rsp_ready=1.
- ADD wrap (macro on): A=4'hF, B=4'h1, op=11 → rsp_data=4'h0, rsp_carry=1, rsp_zero=1. AND with A=4'hC, B=4'h3 → 4'h0, rsp_carry=0.
- Reset in EXEC: pulse rst_n low during EXEC → no response appears; the next tie is granted to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared width, opcode and scheduler state types for alu_ctrl
package alu_pkg;

  localparam int W = 4;

  typedef enum logic [1:0] {
    OP_NOT = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_ADD = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } alu_ctrl_state_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - stateless 4-function ALU (NOT, AND, OR, ADD with carry out)
module alu_core
  import alu_pkg::*;
(
  input  alu_op_e      op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         carry
);

  // carry is only meaningful for ADD and reads 0 for the logic ops
  always_comb begin
    y     = '0;
    carry = 1'b0;
    case (op)
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_ADD:  {carry, y} = {1'b0, a} + {1'b0, b};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - round-robin two-port scheduler for the shared ALU; flags under ALU_CTRL_FLAGS_EN
module alu_ctrl
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [3:0]     req_op,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_data
`ifdef ALU_CTRL_FLAGS_EN
  ,
  output logic           rsp_zero,
  output logic           rsp_carry
`endif
);

  alu_ctrl_state_e state, state_nxt;
  logic            last_grant;
  logic            grant;
  logic            accept;
  alu_op_e         lat_op;
  logic [W-1:0]    lat_a;
  logic [W-1:0]    lat_b;
  logic [W-1:0]    core_y;
  logic            core_carry;

  // On a tie the requester that did not win last time goes first.
  assign grant = (req_valid == 2'b11) ? ~last_grant : req_valid[1];

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          accept    = 1'b1;
          req_ready = grant ? 2'b10 : 2'b01;
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // last_grant doubles as the owner id of the operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      lat_op     <= OP_NOT;
      lat_a      <= '0;
      lat_b      <= '0;
    end else if (accept) begin
      last_grant <= grant;
      lat_op     <= alu_op_e'(grant ? req_op[3:2] : req_op[1:0]);
      lat_a      <= grant ? req_a[2*W-1:W] : req_a[W-1:0];
      lat_b      <= grant ? req_b[2*W-1:W] : req_b[W-1:0];
    end
  end

  alu_core u_core (
    .op    (lat_op),
    .a     (lat_a),
    .b     (lat_b),
    .y     (core_y),
    .carry (core_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_id   <= 1'b0;
    end else if (state == EXEC) begin
      rsp_data <= core_y;
      rsp_id   <= last_grant;
    end
  end

`ifdef ALU_CTRL_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_zero  <= 1'b0;
      rsp_carry <= 1'b0;
    end else if (state == EXEC) begin
      rsp_zero  <= (core_y == '0);
      rsp_carry <= core_carry;
    end
  end
`else
  logic unused_carry;
  assign unused_carry = core_carry;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// tb/tb_alu_ctrl.sv - self-checking bench for alu_ctrl (flag checks under ALU_CTRL_FLAGS_EN)
module tb_alu_ctrl;
  import alu_pkg::*;

  typedef struct { int op; int a; int b; int y; int c; int z; } vec_t;
  typedef struct { int y; int c; int z; } res_t;
  typedef struct { int id; res_t r; int acc; } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [3:0]     req_op;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [W-1:0]   rsp_data;
`ifdef ALU_CTRL_FLAGS_EN
  logic           rsp_zero;
  logic           rsp_carry;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
`ifdef ALU_CTRL_FLAGS_EN
    ,
    .rsp_zero  (rsp_zero),
    .rsp_carry (rsp_carry)
`endif
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Reference ALU from the opcode definitions, using plain integer arithmetic
  function automatic res_t ref_alu(int op, int a, int b);
    res_t r;
    int   m = 1 << W;
    r.c = 0;
    case (op)
      0:       r.y = m - 1 - a;
      1:       r.y = a & b;
      2:       r.y = a | b;
      default: begin
        r.y = (a + b) % m;
        r.c = (a + b >= m) ? 1 : 0;
      end
    endcase
    r.z = (r.y == 0) ? 1 : 0;
    return r;
  endfunction

  task automatic check_rsp(string tag, int id, res_t e);
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_data"}, rsp_data, e.y);
    check({tag, "_id"}, rsp_id, id);
`ifdef ALU_CTRL_FLAGS_EN
    check({tag, "_carry"}, rsp_carry, e.c);
    check({tag, "_zero"}, rsp_zero, e.z);
`endif
  endtask

  task automatic set_req(int r, int op, int a, int b);
    req_valid[r]      = 1'b1;
    req_op[2*r +: 2]  = op[1:0];
    req_a[W*r +: W]   = a[W-1:0];
    req_b[W*r +: W]   = b[W-1:0];
  endtask

  task automatic wait_accept(string tag, output logic [1:0] got, output int at);
    got = 2'b00;
    at  = -1;
    for (int k = 0; k < 16 && got == 2'b00; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        got = req_ready;
        at  = cyc;
      end
    end
    if (got == 2'b00) fail_now({tag, "_accept_timeout"});
  endtask

  // Hold reset with random inputs; afterwards the bench sits at a negedge, idle
  task automatic do_reset();
    logic [1:0] v;
    rst_n     = 1'b0;
    req_valid = 2'($urandom);
    req_op    = 4'($urandom);
    req_a     = (2*W)'($urandom);
    req_b     = (2*W)'($urandom);
    rsp_ready = 1'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    v = req_valid;
    check("reset_valid", rsp_valid, 0);
    check("reset_data", rsp_data, 0);
    check("reset_id", rsp_id, 0);
    check("reset_idle_ready", req_ready, (v == 2'b11) ? 2'b01 : v);
`ifdef ALU_CTRL_FLAGS_EN
    check("reset_zero", rsp_zero, 0);
    check("reset_carry", rsp_carry, 0);
`endif
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[9];
    vec_t       v;
    logic [1:0] got;
    logic [1:0] expg;
    logic [1:0] acc;
    int         at;
    int         prev_at;
    int         r;
    int         id;
    int         last_m;
    bit         hold[2];
    int         op_m[2];
    int         a_m[2];
    int         b_m[2];
    res_t       e;
    exp_t       q[$];

    vecs[0] = '{0, 'hA, 0,   'h5, 0, 0};
    vecs[1] = '{1, 'hC, 'h3, 'h0, 0, 1};
    vecs[2] = '{3, 'hF, 'h1, 'h0, 1, 1};
    vecs[3] = '{2, 'h5, 'hA, 'hF, 0, 0};
    vecs[4] = '{3, 'h7, 'h8, 'hF, 0, 0};
    vecs[5] = '{3, 'h9, 'h9, 'h2, 1, 0};
    vecs[6] = '{0, 'hF, 'h6, 'h0, 0, 1};
    vecs[7] = '{1, 'hF, 'h6, 'h6, 0, 0};
    vecs[8] = '{3, 'h0, 'h0, 'h0, 0, 1};

    req_valid = 2'b00;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    do_reset();

    // Table vectors, alternating single requesters
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      r = i % 2;
      @(posedge clk); #1;
      set_req(r, v.op, v.a, v.b);
      @(negedge clk);
      check("vec_ready", req_ready, (r == 0) ? 2'b01 : 2'b10);
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      check("vec_exec_ready", req_ready, 0);
      check("vec_exec_valid", rsp_valid, 0);
      @(negedge clk);
      check_rsp("vec", r, '{v.y, v.c, v.z});
      @(negedge clk);
      check("vec_drop", rsp_valid, 0);
    end

    // Tie fairness and 3-cycle throughput
    do_reset();
    @(posedge clk); #1;
    set_req(0, 1, 'hF, 'h3);
    set_req(1, 2, 'h8, 'h1);
    prev_at = -1;
    for (int k = 0; k < 4; k++) begin
      wait_accept("tie", got, at);
      check("tie_grant", got, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (prev_at >= 0) check("tie_spacing", at - prev_at, 3);
      prev_at = at;
      @(negedge clk);
      @(negedge clk);
      if (k % 2 == 0) check_rsp("tie_rsp", 0, ref_alu(1, 'hF, 'h3));
      else            check_rsp("tie_rsp", 1, ref_alu(2, 'h8, 'h1));
    end

    // Backpressure with the other requester still waiting
    @(posedge clk); #1;
    set_req(0, 3, 3, 4);
    rsp_ready = 1'b0;
    wait_accept("bp", got, at);
    check("bp_grant", got, 2'b01);
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check_rsp("bp_hold", 0, ref_alu(3, 3, 4));
      check("bp_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check_rsp("bp_done", 0, ref_alu(3, 3, 4));
    check("bp_consume_ready", req_ready, 0);
    @(negedge clk);
    check("bp_released", rsp_valid, 0);
    check("bp_next_grant", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (4) @(posedge clk);

    // Reset during EXEC aborts and restores the tie order
    do_reset();
    @(posedge clk); #1;
    set_req(0, 0, 1, 0);
    set_req(1, 0, 2, 0);
    wait_accept("rst", got, at);
    check("rst_first_grant", got, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("rst_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    req_valid = 2'b11;
    wait_accept("rst_tie", got, at);
    check("rst_tie_grant", got, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (4) @(posedge clk);

    // Random traffic against a transaction-level model
    do_reset();
    last_m = 1;
    acc    = 2'b00;
    hold   = '{0, 0};
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (acc[k]) hold[k] = 0;
        else if (hold[k] && $urandom_range(0, 7) == 0) hold[k] = 0;
        else if (!hold[k] && $urandom_range(0, 1) == 1) begin
          hold[k] = 1;
          op_m[k] = $urandom_range(0, 3);
          a_m[k]  = $urandom_range(0, 15);
          b_m[k]  = $urandom_range(0, 15);
        end
        if (hold[k]) set_req(k, op_m[k], a_m[k], b_m[k]);
        else         req_valid[k] = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (q.size() != 0 || req_valid == 2'b00) expg = 2'b00;
      else if (req_valid == 2'b11)             expg = (last_m == 0) ? 2'b10 : 2'b01;
      else                                     expg = req_valid;
      check("rand_ready", req_ready, expg);
      acc = expg;
      if (expg != 2'b00) begin
        id = expg[1] ? 1 : 0;
        q.push_back('{id, ref_alu(op_m[id], a_m[id], b_m[id]), t});
        last_m = id;
      end
      if (q.size() != 0 && t >= q[0].acc + 2) begin
        check_rsp("rand_rsp", q[0].id, q[0].r);
        if (rsp_ready) void'(q.pop_front());
      end else begin
        check("rand_no_rsp", rsp_valid, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
